// File: rtl/mriscv_decoder_pkg.sv
// Shared decoder encodings: opcodes, operand selects, ALU ops, LSU sizes, WB sources.
// Also holds the funct3-to-ALU-op helpers used by the decoder.
package miriscv_defines;

  localparam int ALU_OP_WIDTH = 5;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  localparam logic [1:0] OP_A_RS1     = 2'd0;
  localparam logic [1:0] OP_A_CURR_PC = 2'd1;
  localparam logic [1:0] OP_A_ZERO    = 2'd2;

  localparam logic [2:0] OP_B_RS2   = 3'd0;
  localparam logic [2:0] OP_B_IMM_I = 3'd1;
  localparam logic [2:0] OP_B_IMM_U = 3'd2;
  localparam logic [2:0] OP_B_IMM_S = 3'd3;
  localparam logic [2:0] OP_B_INCR  = 3'd4;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 5'b11000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 5'b11001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 5'b00111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS = 5'b00010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 5'b00011;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 5'b01111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 5'b00101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 5'b00100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 5'b01110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 5'b10101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 5'b01100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 5'b01101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS  = 5'b00000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GES  = 5'b01010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 5'b00001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU  = 5'b01011;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  localparam logic WB_EX_RESULT = 1'b0;
  localparam logic WB_LSU_DATA  = 1'b1;

  // alt selects SUB for funct3=0 and SRA for funct3=5
  function automatic logic [ALU_OP_WIDTH-1:0] alu_arith(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_arith = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_arith = ALU_SLL;
      3'd2:    alu_arith = ALU_SLTS;
      3'd3:    alu_arith = ALU_SLTU;
      3'd4:    alu_arith = ALU_XOR;
      3'd5:    alu_arith = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_arith = ALU_OR;
      default: alu_arith = ALU_AND;
    endcase
  endfunction

  function automatic logic [ALU_OP_WIDTH-1:0] alu_branch(input logic [2:0] f3);
    case (f3)
      3'd0:    alu_branch = ALU_EQ;
      3'd1:    alu_branch = ALU_NE;
      3'd4:    alu_branch = ALU_LTS;
      3'd5:    alu_branch = ALU_GES;
      3'd6:    alu_branch = ALU_LTU;
      3'd7:    alu_branch = ALU_GEU;
      default: alu_branch = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mriscv_decoder.sv
// RV32I main decoder: combinational control decode of one instruction word.
// MRISCV_DECODER_ILLEGAL_CNT_EN adds a saturating illegal-instruction counter (illegal_cnt_o).
module mriscv_decoder
  import miriscv_defines::*;
(
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic [31:0]             fetched_instr_i,
  output logic [1:0]              ex_op_a_sel_o,
  output logic [2:0]              ex_op_b_sel_o,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [2:0]              mem_size_o,
  output logic                    gpr_we_a_o,
  output logic                    wb_src_sel_o,
  output logic                    illegal_instr_o,
  output logic                    branch_o,
  output logic                    jal_o,
  output logic                    jalr_o
`ifdef MRISCV_DECODER_ILLEGAL_CNT_EN
  ,
  output logic [7:0]              illegal_cnt_o
`endif
);

  logic [4:0] w_opcode;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_f7_zero;
  logic       w_f7_alt;

  assign w_opcode  = fetched_instr_i[6:2];
  assign w_f3      = fetched_instr_i[14:12];
  assign w_f7      = fetched_instr_i[31:25];
  assign w_f7_zero = (w_f7 == 7'h00);
  assign w_f7_alt  = (w_f7 == 7'h20);

  logic                    w_illegal;
  logic [1:0]              w_op_a;
  logic [2:0]              w_op_b;
  logic [ALU_OP_WIDTH-1:0] w_alu;
  logic                    w_mem_req;
  logic                    w_mem_we;
  logic [2:0]              w_mem_size;
  logic                    w_gpr_we;
  logic                    w_wb_sel;
  logic                    w_branch;
  logic                    w_jal;
  logic                    w_jalr;

  always_comb begin
    w_illegal  = 1'b0;
    w_op_a     = OP_A_RS1;
    w_op_b     = OP_B_RS2;
    w_alu      = ALU_ADD;
    w_mem_req  = 1'b0;
    w_mem_we   = 1'b0;
    w_mem_size = LDST_W;
    w_gpr_we   = 1'b0;
    w_wb_sel   = WB_EX_RESULT;
    w_branch   = 1'b0;
    w_jal      = 1'b0;
    w_jalr     = 1'b0;

    if (fetched_instr_i[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end else begin
      case (w_opcode)
        OPC_LOAD: begin
          w_illegal  = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
          w_op_b     = OP_B_IMM_I;
          w_mem_req  = 1'b1;
          w_mem_size = w_f3;
          w_gpr_we   = 1'b1;
          w_wb_sel   = WB_LSU_DATA;
        end
        OPC_MISC_MEM, OPC_SYSTEM: ;
        OPC_OP_IMM: begin
          w_illegal = ((w_f3 == 3'd1) && !w_f7_zero) ||
                      ((w_f3 == 3'd5) && !w_f7_zero && !w_f7_alt);
          w_op_b    = OP_B_IMM_I;
          w_alu     = alu_arith(w_f3, (w_f3 == 3'd5) && w_f7_alt);
          w_gpr_we  = 1'b1;
        end
        OPC_AUIPC: begin
          w_op_a   = OP_A_CURR_PC;
          w_op_b   = OP_B_IMM_U;
          w_gpr_we = 1'b1;
        end
        OPC_STORE: begin
          w_illegal  = w_f3[2];
          w_op_b     = OP_B_IMM_S;
          w_mem_req  = 1'b1;
          w_mem_we   = 1'b1;
          w_mem_size = w_f3;
        end
        OPC_OP: begin
          w_illegal = !(w_f7_zero || (w_f7_alt && ((w_f3 == 3'd0) || (w_f3 == 3'd5))));
          w_alu     = alu_arith(w_f3, w_f7_alt);
          w_gpr_we  = 1'b1;
        end
        OPC_LUI: begin
          w_op_a   = OP_A_ZERO;
          w_op_b   = OP_B_IMM_U;
          w_gpr_we = 1'b1;
        end
        OPC_BRANCH: begin
          w_illegal = (w_f3 == 3'd2) || (w_f3 == 3'd3);
          w_alu     = alu_branch(w_f3);
          w_branch  = 1'b1;
        end
        OPC_JALR: begin
          w_op_a   = OP_A_CURR_PC;
          w_op_b   = OP_B_INCR;
          w_gpr_we = 1'b1;
          w_jalr   = 1'b1;
        end
        OPC_JAL: begin
          w_op_a   = OP_A_CURR_PC;
          w_op_b   = OP_B_INCR;
          w_gpr_we = 1'b1;
          w_jal    = 1'b1;
        end
        default: w_illegal = 1'b1;
      endcase
    end

    // Illegal words collapse to a harmless RS1+RS2 ADD with every side effect off
    if (w_illegal) begin
      w_op_a     = OP_A_RS1;
      w_op_b     = OP_B_RS2;
      w_alu      = ALU_ADD;
      w_mem_req  = 1'b0;
      w_mem_we   = 1'b0;
      w_mem_size = LDST_W;
      w_gpr_we   = 1'b0;
      w_wb_sel   = WB_EX_RESULT;
      w_branch   = 1'b0;
      w_jal      = 1'b0;
      w_jalr     = 1'b0;
    end
  end

  assign illegal_instr_o = w_illegal;
  assign ex_op_a_sel_o   = w_op_a;
  assign ex_op_b_sel_o   = w_op_b;
  assign alu_op_o        = w_alu;
  assign mem_req_o       = w_mem_req;
  assign mem_we_o        = w_mem_we;
  assign mem_size_o      = w_mem_size;
  assign gpr_we_a_o      = w_gpr_we;
  assign wb_src_sel_o    = w_wb_sel;
  assign branch_o        = w_branch;
  assign jal_o           = w_jal;
  assign jalr_o          = w_jalr;

`ifdef MRISCV_DECODER_ILLEGAL_CNT_EN
  logic [7:0] r_illegal_cnt;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_illegal_cnt <= 8'd0;
    end else if (w_illegal && (r_illegal_cnt != 8'hFF)) begin
      r_illegal_cnt <= r_illegal_cnt + 8'd1;
    end
  end

  assign illegal_cnt_o = r_illegal_cnt;

  logic w_unused;
  assign w_unused = ^{fetched_instr_i[24:15], fetched_instr_i[11:7]};
`else
  // Register fields, clock and reset have no effect on decode in this build
  logic w_unused;
  assign w_unused = ^{clk_i, arstn_i, fetched_instr_i[24:15], fetched_instr_i[11:7]};
`endif

endmodule

// File: tb/tb_mriscv_decoder.sv
// Directed and random checks of mriscv_decoder against hand-derived expectations.
// Exercises the illegal counter when MRISCV_DECODER_ILLEGAL_CNT_EN is defined.
module tb_mriscv_decoder;

  typedef struct packed {
    logic       ill;
    logic [1:0] a;
    logic [2:0] b;
    logic [4:0] alu;
    logic       req;
    logic       we;
    logic [2:0] size;
    logic       gpr;
    logic       wb;
    logic       br;
    logic       jal;
    logic       jalr;
  } dec_t;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic [31:0] instr = 32'h0000_0013;
  logic [1:0]  op_a;
  logic [2:0]  op_b;
  logic [4:0]  alu;
  logic        mem_req, mem_we, gpr_we, wb_sel, ill, br, jal, jalr;
  logic [2:0]  mem_size;
`ifdef MRISCV_DECODER_ILLEGAL_CNT_EN
  logic [7:0]  cnt;
`endif

  int total = 0;
  int bad = 0;
  dec_t      exp_q[$];
  string     tag_q[$];

  always #5 clk = ~clk;

  mriscv_decoder dut (
    .clk_i           (clk),
    .arstn_i         (arstn),
    .fetched_instr_i (instr),
    .ex_op_a_sel_o   (op_a),
    .ex_op_b_sel_o   (op_b),
    .alu_op_o        (alu),
    .mem_req_o       (mem_req),
    .mem_we_o        (mem_we),
    .mem_size_o      (mem_size),
    .gpr_we_a_o      (gpr_we),
    .wb_src_sel_o    (wb_sel),
    .illegal_instr_o (ill),
    .branch_o        (br),
    .jal_o           (jal),
    .jalr_o          (jalr)
`ifdef MRISCV_DECODER_ILLEGAL_CNT_EN
    ,
    .illegal_cnt_o   (cnt)
`endif
  );

  function automatic dec_t mk(input logic i, input logic [1:0] a, input logic [2:0] b,
                              input logic [4:0] al, input logic rq, input logic w,
                              input logic [2:0] sz, input logic g, input logic wbs,
                              input logic bb, input logic jl, input logic jr);
    dec_t d;
    d = '{ill: i, a: a, b: b, alu: al, req: rq, we: w, size: sz, gpr: g, wb: wbs,
          br: bb, jal: jl, jalr: jr};
    return d;
  endfunction

  function automatic dec_t observed();
    return '{ill: ill, a: op_a, b: op_b, alu: alu, req: mem_req, we: mem_we,
             size: mem_size, gpr: gpr_we, wb: wb_sel, br: br, jal: jal, jalr: jalr};
  endfunction

  function automatic bit alu_legal(input logic [4:0] v);
    case (v)
      5'b11000, 5'b11001, 5'b00111, 5'b00010, 5'b00011, 5'b01111, 5'b00101, 5'b00100,
      5'b01110, 5'b10101, 5'b01100, 5'b01101, 5'b00000, 5'b01010, 5'b00001, 5'b01011:
        return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive a word and record what the decoder must produce for it
  task automatic drive(input string tag, input logic [31:0] w, input dec_t e);
    @(negedge clk);
    instr = w;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check();
    dec_t e, o;
    string t;
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = observed();
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s instr=%h observed=%h expected=%h", t, instr, o, e);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] w, input dec_t e);
    drive(tag, w, e);
    check();
  endtask

  initial begin
    dec_t d_ill;
    d_ill = mk(1, 0, 0, 5'b11000, 0, 0, 2, 0, 0, 0, 0, 0);

    // Decode is live while reset is asserted
    step("addi_in_reset", 32'h0000_0013, mk(0, 0, 1, 5'b11000, 0, 0, 2, 1, 0, 0, 0, 0));
    step("jal_in_reset",  32'h0000_00EF, mk(0, 1, 4, 5'b11000, 0, 0, 2, 1, 0, 0, 1, 0));
`ifdef MRISCV_DECODER_ILLEGAL_CNT_EN
    total++;
    assert (cnt === 8'd0) else begin
      bad++;
      $error("FAIL cnt_reset observed=%0d expected=0", cnt);
    end
`endif
    @(negedge clk);
    arstn = 1'b1;

    step("addi",   32'h0000_0013, mk(0, 0, 1, 5'b11000, 0, 0, 2, 1, 0, 0, 0, 0));
    step("sub",    32'h40B5_0533, mk(0, 0, 0, 5'b11001, 0, 0, 2, 1, 0, 0, 0, 0));
    step("lw",     32'h0005_2503, mk(0, 0, 1, 5'b11000, 1, 0, 2, 1, 1, 0, 0, 0));
    step("sw",     32'h00A5_2023, mk(0, 0, 3, 5'b11000, 1, 1, 2, 0, 0, 0, 0, 0));
    step("bne",    32'h00B5_1463, mk(0, 0, 0, 5'b01101, 0, 0, 2, 0, 0, 1, 0, 0));
    step("jal",    32'h0000_00EF, mk(0, 1, 4, 5'b11000, 0, 0, 2, 1, 0, 0, 1, 0));
    step("jalr",   32'h0005_00E7, mk(0, 1, 4, 5'b11000, 0, 0, 2, 1, 0, 0, 0, 1));
    step("lui",    32'h1234_52B7, mk(0, 2, 2, 5'b11000, 0, 0, 2, 1, 0, 0, 0, 0));
    step("auipc",  32'h0000_0297, mk(0, 1, 2, 5'b11000, 0, 0, 2, 1, 0, 0, 0, 0));
    step("srai",   32'h4055_5513, mk(0, 0, 1, 5'b00100, 0, 0, 2, 1, 0, 0, 0, 0));
    step("xori",   32'h00F5_4513, mk(0, 0, 1, 5'b01111, 0, 0, 2, 1, 0, 0, 0, 0));
    step("slti",   32'hFFF5_2513, mk(0, 0, 1, 5'b00010, 0, 0, 2, 1, 0, 0, 0, 0));
    step("and",    32'h00B5_7533, mk(0, 0, 0, 5'b10101, 0, 0, 2, 1, 0, 0, 0, 0));
    step("lbu",    32'h0005_4503, mk(0, 0, 1, 5'b11000, 1, 0, 4, 1, 1, 0, 0, 0));
    step("sh",     32'h00A5_1023, mk(0, 0, 3, 5'b11000, 1, 1, 1, 0, 0, 0, 0, 0));
    step("bgeu",   32'h00B5_7463, mk(0, 0, 0, 5'b01011, 0, 0, 2, 0, 0, 1, 0, 0));
    step("fence",  32'h0000_000F, mk(0, 0, 0, 5'b11000, 0, 0, 2, 0, 0, 0, 0, 0));
    step("ecall",  32'h0000_0073, mk(0, 0, 0, 5'b11000, 0, 0, 2, 0, 0, 0, 0, 0));
    step("ld_f3_3",      32'h0000_3003, d_ill);
    step("slli_f7_01",   32'h0205_1513, d_ill);
    step("low_bits_10",  32'h0000_0012, d_ill);
    step("op_f7_20_f3_1", 32'h40B5_1533, d_ill);
    step("st_f3_4",      32'h00A5_4023, d_ill);
    step("br_f3_2",      32'h00B5_2463, d_ill);
    step("opc_11111",    32'h0000_007F, d_ill);

    // Random words: every select must stay in its legal set, illegal must be inert
    for (int k = 0; k < 200; k++) begin
      bit ok;
      @(negedge clk);
      instr = $urandom();
      if (k % 2 == 0) instr[1:0] = 2'b11;
      #1;
      ok = (op_a <= 2'd2) && (op_b <= 3'd4) && alu_legal(alu) &&
           (mem_size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (ill) ok = ok && !mem_req && !mem_we && !gpr_we && !br && !jal && !jalr;
      total++;
      assert (ok === 1'b1) else begin
        bad++;
        $error("FAIL rand_legal_set instr=%h observed a=%0d b=%0d alu=%b size=%0d expected legal",
               instr, op_a, op_b, alu, mem_size);
      end
    end

`ifdef MRISCV_DECODER_ILLEGAL_CNT_EN
    @(negedge clk);
    arstn = 1'b0;
    instr = 32'h0000_0013;
    @(negedge clk);
    arstn = 1'b1;
    instr = 32'h0000_0012;
    repeat (3) @(negedge clk);
    instr = 32'h0000_0013;
    #1;
    total++;
    assert (cnt === 8'd3) else begin
      bad++;
      $error("FAIL cnt_three observed=%0d expected=3", cnt);
    end
    instr = 32'h0000_0012;
    repeat (300) @(negedge clk);
    #1;
    total++;
    assert (cnt === 8'd255) else begin
      bad++;
      $error("FAIL cnt_saturate observed=%0d expected=255", cnt);
    end
    arstn = 1'b0;
    #1;
    total++;
    assert (cnt === 8'd0) else begin
      bad++;
      $error("FAIL cnt_async_clear observed=%0d expected=0", cnt);
    end
    arstn = 1'b1;
    instr = 32'h0000_0013;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
